// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through channels 0..3, samples y after a settle
// window and hands the 4-bit snapshot downstream. Optional: MUX_SCAN_PARITY_EN.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  // A zero settle time skips the SETTLE state entirely.
  localparam state_e FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        sel_d = 2'd0;
        if (start) begin
          busy_d  = 1'b1;
          state_d = FIRST;
          cnt_d   = RELOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else cnt_d = cnt_q - 1'b1;
      end
      SAMPLE: begin
        shadow_d[sel_q] = y;
        if (sel_q == 2'd3) begin
          data_d  = {y, shadow_q[2:0]};
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 2'd1;
          state_d = FIRST;
          cnt_d   = RELOAD;
        end
      end
      DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          sel_d   = 2'd0;
          if (start) begin
            state_d = FIRST;
            cnt_d   = RELOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= 4'd0;
      data_q   <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^data_d;
  end

  assign parity = parity_q;
`endif

  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign busy  = busy_q;
  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: SETTLE_CYCLES=2 and =0 instances share
// stimulus; a timeline model checks every cycle, plus literal checks.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] mux_in = 4'd0;

  logic [1:0] s1_w, s0_w, busy_w, valid_w, y_w;
  logic [3:0] data_w [2];
`ifdef MUX_SCAN_PARITY_EN
  logic [1:0] parity_w;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int S = (g == 0) ? 2 : 0;

    assign y_w[g] = mux_in[{s1_w[g], s0_w[g]}];

    mux_scan_sequencer #(
      .SETTLE_CYCLES(S),
      .CNT_W(4)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .y     (y_w[g]),
      .s1    (s1_w[g]),
      .s0    (s0_w[g]),
      .busy  (busy_w[g]),
      .data  (data_w[g]),
      .valid (valid_w[g]),
      .ready (ready)
`ifdef MUX_SCAN_PARITY_EN
      ,
      .parity(parity_w[g])
`endif
    );

    // Model: a scan is a timeline of 4*(S+1) cycles; channel = t/(S+1),
    // sampled on the last cycle of its window.
    bit         m_busy = 1'b0;
    bit         m_valid = 1'b0;
    int         m_t = 0;
    logic [3:0] m_word = 4'd0;
    logic [3:0] m_data = 4'd0;

    always @(posedge clk or negedge rst_n) begin : model
      int         ch;
      logic [3:0] w;
      if (!rst_n) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_t     <= 0;
        m_word  <= 4'd0;
        m_data  <= 4'd0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_t    <= 0;
        end
      end else if (!m_valid) begin
        ch = m_t / (S + 1);
        w  = m_word;
        if (m_t % (S + 1) == S) begin
          w[ch] = mux_in[ch];
          if (ch == 3) begin
            m_valid <= 1'b1;
            m_data  <= w;
          end
        end
        m_word <= w;
        m_t    <= m_t + 1;
      end else if (ready) begin
        m_valid <= 1'b0;
        m_t     <= 0;
        if (!start) m_busy <= 1'b0;
      end
    end

    always @(posedge clk) begin : compare
      int         es;
      logic [7:0] e;
      logic [7:0] a;
      #1;
      es = !m_busy ? 0 : (m_valid ? 3 : m_t / (S + 1));
      e  = {es[1:0], m_busy, m_valid, m_data};
      a  = {s1_w[g], s0_w[g], busy_w[g], valid_w[g], data_w[g]};
      chk(g == 0 ? "cycle_s2" : "cycle_s0", a, e);
`ifdef MUX_SCAN_PARITY_EN
      chk(g == 0 ? "par_s2" : "par_s0", {7'd0, parity_w[g]},
          {7'd0, ^m_data});
`endif
    end
  end

  task automatic wait_valid(input int g);
    int n;
    n = 0;
    while (!valid_w[g] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid", {7'd0, valid_w[g]}, 8'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_outs", {s1_w[0], s0_w[0], busy_w[0], valid_w[0],
                        data_w[0]}, 8'h00);
    end

    // single scan, settle 2, inputs 1010
    @(negedge clk);
    mux_in = 4'b1010;
    ready  = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 chk("valid_e11", {7'd0, valid_w[0]}, 8'd0);
    @(posedge clk);
    #1 chk("valid_e12", {busy_w[0], valid_w[0], 2'b0, data_w[0]},
           8'hCA);
    @(posedge clk);
    #1 chk("done_e13", {busy_w[0], valid_w[0], 2'b0, data_w[0]},
           8'h0A);

    // backpressure with ignored start pulses
    repeat (3) @(negedge clk);
    ready = 1'b0;
    pulse_start();
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      @(posedge clk);
      #1 chk("bp_hold", {valid_w[0], 3'd0, data_w[0]}, 8'h8A);
    end
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release", {busy_w[0], valid_w[0], s1_w[0], s0_w[0]},
           8'h0);

    // back-to-back, settle 0
    repeat (3) @(negedge clk);
    mux_in = 4'b0110;
    start  = 1'b1;
    wait_valid(1);
    chk("b2b_word1", {4'd0, data_w[1]}, 8'h06);
    @(negedge clk);
    mux_in = 4'b1001;
    repeat (5) begin
      @(posedge clk);
      #1 chk("b2b_busy", {7'd0, busy_w[1]}, 8'd1);
    end
    chk("b2b_word2", {valid_w[1], 3'd0, data_w[1]}, 8'h89);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // reset mid-scan at channel 2
    mux_in = 4'b1111;
    pulse_start();
    n = 0;
    while (!(s1_w[0] && !s0_w[0]) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sel2_reached", {6'd0, s1_w[0], s0_w[0]}, 8'd2);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {s1_w[0], s0_w[0], busy_w[0], valid_w[0],
                         data_w[0]}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_valid(0);
    chk("after_rst", {4'd0, data_w[0]}, 8'h0F);
    repeat (10) @(negedge clk);

`ifdef MUX_SCAN_PARITY_EN
    mux_in = 4'b1011;
    pulse_start();
    wait_valid(0);
    chk("parity_1011", {7'd0, parity_w[0]}, 8'd1);
    repeat (10) @(negedge clk);
    mux_in = 4'b1001;
    pulse_start();
    wait_valid(0);
    chk("parity_1001", {7'd0, parity_w[0]}, 8'd0);
    repeat (10) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
